// File: rtl/ft_arb_pkg.sv
// rtl/ft_arb_pkg.sv - shared types and defaults for the FT245 bus arbiter
package ft_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_STROBE,
        ST_RD_HOLD,
        ST_TURN,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_WR_HOLD
    } ft_arb_state_e;

    localparam logic DIR_RX = 1'b0;
    localparam logic DIR_TX = 1'b1;

    localparam int DEF_STROBE_CYC = 3;
    localparam int DEF_HOLD_CYC   = 3;
    localparam int DEF_TURN_CYC   = 2;
    localparam int DEF_MAX_BURST  = 16;

    // Largest of the phase lengths, used to size the shared phase counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/ft_flag_sync.sv
// rtl/ft_flag_sync.sv - two-flop synchronizer for active-low FT2232H flags
module ft_flag_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Resets to all-ones so an unsynchronized flag reads as "inactive"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ft_bus_arbiter.sv
// rtl/ft_bus_arbiter.sv - FT245 async FIFO bus sequencer/arbiter (optional FT_ARB_BURST_EN)
module ft_bus_arbiter
    import ft_arb_pkg::*;
#(
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int TURN_CYC   = DEF_TURN_CYC,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rxf_n,
    input  logic txe_n,
    input  logic rx_afull,
    input  logic tx_empty,
    output logic rd_n,
    output logic wr_n,
    output logic bus_oe,
    output logic rx_push,
    output logic tx_pop,
    output logic dir,
    output logic busy
);

    localparam int CNT_MAX = max3(STROBE_CYC, HOLD_CYC, TURN_CYC);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] TURN_LAST   = CW'(TURN_CYC - 1);
    localparam logic [CW-1:0] PUSH_PRE    = CW'((STROBE_CYC > 1) ? STROBE_CYC - 2 : 0);
    // A one-cycle strobe must raise rx_push on the very cycle it goes low
    localparam logic          PUSH_ENTRY  = (STROBE_CYC == 1);

    // Elaboration-time parameter sanity checks
    if (STROBE_CYC < 1) begin : g_chk_strobe
        $error("STROBE_CYC must be at least 1");
    end
    if (HOLD_CYC < 3) begin : g_chk_hold
        $error("HOLD_CYC must be at least 3 to cover flag synchronizer latency");
    end
    if (TURN_CYC < 1) begin : g_chk_turn
        $error("TURN_CYC must be at least 1");
    end
    if (MAX_BURST < 1) begin : g_chk_burst
        $error("MAX_BURST must be at least 1");
    end

    ft_arb_state_e state;
    logic [CW-1:0] cnt;
    logic          rxf_s;
    logic          txe_s;
    logic          rd_ok;
    logic          wr_ok;
    logic          rd_more;
    logic          wr_more;

    ft_flag_sync #(.WIDTH(1)) u_rxf_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxf_n),
        .q     (rxf_s)
    );

    ft_flag_sync #(.WIDTH(1)) u_txe_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (txe_n),
        .q     (txe_s)
    );

    assign rd_ok = !rxf_s && !rx_afull;
    assign wr_ok = !txe_s && !tx_empty;

`ifdef FT_ARB_BURST_EN
    localparam int BW = $clog2(MAX_BURST) + 1;

    logic [BW-1:0] burst_cnt;
    logic          burst_full;
    logic          byte_done;

    assign burst_full = (burst_cnt >= BW'(MAX_BURST));
    assign byte_done  = ((state == ST_RD_STROBE) || (state == ST_WR_STROBE)) && (cnt == STROBE_LAST);
    assign rd_more    = rd_ok && !burst_full;
    assign wr_more    = wr_ok && !burst_full;

    // Bytes completed in the current grant; cleared while idle, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (state == ST_IDLE) begin
            burst_cnt <= '0;
        end else if (byte_done && (burst_cnt != '1)) begin
            burst_cnt <= burst_cnt + BW'(1);
        end
    end
`else
    assign rd_more = rd_ok;
    assign wr_more = wr_ok;
`endif

    // Bus sequencer: arbitration, strobe timing and data-bus turnaround
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            bus_oe  <= 1'b0;
            rx_push <= 1'b0;
            tx_pop  <= 1'b0;
            dir     <= DIR_TX;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    // On a tie the direction not served last time wins
                    if (rd_ok && (!wr_ok || (dir == DIR_TX))) begin
                        dir  <= DIR_RX;
                        busy <= 1'b1;
                        if (bus_oe) begin
                            state  <= ST_TURN;
                            bus_oe <= 1'b0;
                        end else begin
                            state   <= ST_RD_STROBE;
                            rd_n    <= 1'b0;
                            rx_push <= PUSH_ENTRY;
                        end
                    end else if (wr_ok) begin
                        dir  <= DIR_TX;
                        busy <= 1'b1;
                        if (!bus_oe) begin
                            state  <= ST_WR_SETUP;
                            bus_oe <= 1'b1;
                        end else begin
                            state <= ST_WR_STROBE;
                            wr_n  <= 1'b0;
                        end
                    end
                end

                ST_TURN: begin
                    if (cnt == TURN_LAST) begin
                        cnt     <= '0;
                        state   <= ST_RD_STROBE;
                        rd_n    <= 1'b0;
                        rx_push <= PUSH_ENTRY;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_RD_STROBE: begin
                    if (cnt == STROBE_LAST) begin
                        cnt     <= '0;
                        state   <= ST_RD_HOLD;
                        rd_n    <= 1'b1;
                        rx_push <= 1'b0;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        rx_push <= (cnt == PUSH_PRE);
                    end
                end

                ST_RD_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        if (rd_more) begin
                            state   <= ST_RD_STROBE;
                            rd_n    <= 1'b0;
                            rx_push <= PUSH_ENTRY;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_WR_SETUP: begin
                    cnt   <= '0;
                    state <= ST_WR_STROBE;
                    wr_n  <= 1'b0;
                end

                ST_WR_STROBE: begin
                    if (cnt == STROBE_LAST) begin
                        cnt    <= '0;
                        state  <= ST_WR_HOLD;
                        wr_n   <= 1'b1;
                        tx_pop <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_WR_HOLD: begin
                    tx_pop <= 1'b0;
                    if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        if (wr_more) begin
                            state <= ST_WR_STROBE;
                            wr_n  <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft_bus_arbiter.sv
// tb/tb_ft_bus_arbiter.sv - randomized self-checking bench for ft_bus_arbiter
module tb_ft_bus_arbiter;

    localparam int STROBE = 3;
    localparam int HOLD   = 3;
    localparam int TURN   = 2;
    localparam int MAXB   = 16;
`ifdef FT_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, rxf_n, txe_n, rx_afull, tx_empty;
    logic rd_n, wr_n, bus_oe, rx_push, tx_pop, dir, busy;

    ft_bus_arbiter #(
        .STROBE_CYC (STROBE),
        .HOLD_CYC   (HOLD),
        .TURN_CYC   (TURN),
        .MAX_BURST  (MAXB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxf_n    (rxf_n),
        .txe_n    (txe_n),
        .rx_afull (rx_afull),
        .tx_empty (tx_empty),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .bus_oe   (bus_oe),
        .rx_push  (rx_push),
        .tx_pop   (tx_pop),
        .dir      (dir),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Environment: bytes offered by the FT2232H and words queued in the tx FIFO
    int rx_added = 0, tx_added = 0;
    bit txe_block = 1'b1;
    // Observed traffic
    int push_cnt = 0, pop_cnt = 0, rd_pulses = 0, wr_pulses = 0, oe_rises = 0;
    int cyc = 0, last_rd_fall = 0, last_wr_fall = 0;
    int rd_run = 0, wr_run = 0, oe_low_run = 0, oe_high_run = 0;
    logic rd_prev = 1'b1, wr_prev = 1'b1, oe_prev = 1'b0;
    bit last_was_tx = 1'b0, need_setup = 1'b0, per_chk = 1'b0;
    int rx_base = 0, tx_base = 0;
    bit seen[$];

    // Expected fall-to-fall spacing before byte k (k bytes already sent in this stream)
    function automatic int exp_gap(input int k);
        if (BURST && (k % MAXB == 0)) return STROBE + HOLD + 1;
        return STROBE + HOLD;
    endfunction

    // Protocol monitor and flag model, sampled on the falling edge
    initial begin
        rxf_n = 1'b1;
        txe_n = 1'b1;
        tx_empty = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                rd_prev = 1'b1; wr_prev = 1'b1; oe_prev = 1'b0;
                rd_run = 0; wr_run = 0; oe_low_run = 0; oe_high_run = 0;
            end else begin
                check("rd_wr_excl", {31'd0, rd_n | wr_n}, 1);
                if (!rd_n) check("rd_vs_oe", {31'd0, bus_oe}, 0);
                if (!wr_n) check("wr_vs_oe", {31'd0, bus_oe}, 1);
                if (rd_prev && !rd_n) begin
                    rd_pulses++;
                    if (per_chk && (rd_pulses - rx_base > 1))
                        check("rd_period", cyc - last_rd_fall, exp_gap(rd_pulses - rx_base - 1));
                    if (last_was_tx) check("turn_len", oe_low_run, TURN);
                    last_rd_fall = cyc;
                end
                if (wr_prev && !wr_n) begin
                    wr_pulses++;
                    if (per_chk && (wr_pulses - tx_base > 1))
                        check("wr_period", cyc - last_wr_fall, exp_gap(wr_pulses - tx_base - 1));
                    if (need_setup) check("setup_len", oe_high_run, 1);
                    need_setup = 1'b0;
                    last_wr_fall = cyc;
                end
                if (!rd_n) rd_run++;
                if (!wr_n) wr_run++;
                if (!rd_prev && rd_n) begin
                    check("rd_width", rd_run, STROBE);
                    rd_run = 0;
                end
                if (!wr_prev && wr_n) begin
                    check("wr_width", wr_run, STROBE);
                    wr_run = 0;
                end
                if (rx_push) begin
                    check("push_align", {31'd0, !rd_n && (rd_run == STROBE)}, 1);
                    push_cnt++;
                    seen.push_back(1'b0);
                    last_was_tx = 1'b0;
                end
                if (tx_pop) begin
                    check("pop_align", {31'd0, !wr_prev && wr_n}, 1);
                    pop_cnt++;
                    seen.push_back(1'b1);
                    last_was_tx = 1'b1;
                end
                if (bus_oe && !oe_prev) begin
                    oe_rises++;
                    need_setup = 1'b1;
                end
                oe_low_run  = bus_oe ? 0 : oe_low_run + 1;
                oe_high_run = bus_oe ? oe_high_run + 1 : 0;
                rd_prev = rd_n;
                wr_prev = wr_n;
                oe_prev = bus_oe;
            end
            rxf_n    = (rx_added == push_cnt);
            tx_empty = (tx_added == pop_cnt);
            txe_n    = txe_block;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!((rx_added == push_cnt) && (tx_added == pop_cnt) && !busy) && (t < 3000)) begin
            tick();
            t++;
        end
        if (t >= 3000) check("timeout", 0, 1);
        repeat (8) tick();
    endtask

    bit last_dir = 1'b1;
    bit oe_model = 1'b0;

    task automatic rx_only(input int n);
        int p0;
        rx_base = rd_pulses; tx_base = wr_pulses; per_chk = 1'b1;
        p0 = push_cnt;
        rx_added += n;
        wait_done();
        per_chk = 1'b0;
        check("rx_pushes", push_cnt - p0, n);
        check("rx_strobes", rd_pulses - rx_base, n);
        check("rx_no_wr", wr_pulses - tx_base, 0);
        check("rx_dir", {31'd0, dir}, 0);
        check("rx_idle", {31'd0, busy}, 0);
        check("rx_oe", {31'd0, bus_oe}, 0);
        last_dir = 1'b0; oe_model = 1'b0;
    endtask

    task automatic tx_only(input int m);
        int p0, o0;
        rx_base = rd_pulses; tx_base = wr_pulses; per_chk = 1'b1;
        p0 = pop_cnt; o0 = oe_rises;
        txe_block = 1'b0;
        tx_added += m;
        wait_done();
        per_chk = 1'b0;
        check("tx_pops", pop_cnt - p0, m);
        check("tx_strobes", wr_pulses - tx_base, m);
        check("tx_setups", oe_rises - o0, oe_model ? 0 : 1);
        check("tx_oe_after", {31'd0, bus_oe}, 1);
        check("tx_dir", {31'd0, dir}, 1);
        last_dir = 1'b1; oe_model = 1'b1;
    endtask

    task automatic both_ready(input int n, input int m);
        bit expq[$];
        int r, t, take, s0;
        bit d;
        r = n; t = m;
        while ((r > 0) || (t > 0)) begin
            if ((r > 0) && (t > 0)) d = !last_dir;
            else d = (t > 0);
            take = d ? t : r;
            if (BURST && (take > MAXB)) take = MAXB;
            repeat (take) expq.push_back(d);
            if (d) t -= take; else r -= take;
            last_dir = d;
        end
        txe_block = 1'b1;
        repeat (5) tick();
        s0 = seen.size();
        tx_added += m;
        rx_added += n;
        txe_block = 1'b0;
        wait_done();
        check("both_count", seen.size() - s0, expq.size());
        for (int i = 0; i < expq.size() && (s0 + i) < seen.size(); i++)
            check("both_order", {31'd0, seen[s0 + i]}, {31'd0, expq[i]});
        check("both_dir", {31'd0, dir}, {31'd0, last_dir});
        oe_model = last_dir;
    endtask

    task automatic backpressure(input int n, input int k);
        int p0, r0, t;
        p0 = push_cnt; r0 = rd_pulses; t = 0;
        rx_added += n;
        while (!(!rd_n && (rd_pulses - r0 == k)) && (t < 1000)) begin
            tick();
            t++;
        end
        if (t >= 1000) check("bp_timeout", 0, 1);
        rx_afull = 1'b1;
        repeat (60) tick();
        check("bp_pushes", push_cnt - p0, k);
        check("bp_strobes", rd_pulses - r0, k);
        check("bp_idle", {31'd0, busy}, 0);
        rx_afull = 1'b0;
        wait_done();
        check("bp_resume", push_cnt - p0, n);
        last_dir = 1'b0; oe_model = 1'b0;
    endtask

    initial begin
        int t, p0, w0;
        rst_n = 1'b0;
        rx_afull = 1'b0;
        repeat (3) begin
            tick();
            check("reset_out", {25'd0, rd_n, wr_n, bus_oe, rx_push, tx_pop, dir, busy}, 7'b1100010);
        end
        rst_n = 1'b1;
        repeat (20) begin
            tick();
            check("idle_out", {25'd0, rd_n, wr_n, bus_oe, rx_push, tx_pop, dir, busy}, 7'b1100010);
        end

        rx_only(20);
        tx_only(5);
        tx_only($urandom_range(20, 2));
        rx_only($urandom_range(40, 2));
        both_ready($urandom_range(40, 10), $urandom_range(40, 10));
        both_ready($urandom_range(40, 10), $urandom_range(40, 10));
        backpressure(10, $urandom_range(8, 2));

        // Reset in the middle of the second write strobe
        txe_block = 1'b0;
        w0 = wr_pulses;
        tx_added += 5;
        t = 0;
        while (!(!wr_n && (wr_pulses - w0 == 2)) && (t < 1000)) begin
            tick();
            t++;
        end
        if (t >= 1000) check("mr_timeout", 0, 1);
        p0 = pop_cnt;
        rst_n = 1'b0;
        #1;
        check("mr_wr_n", {31'd0, wr_n}, 1);
        check("mr_bus_oe", {31'd0, bus_oe}, 0);
        check("mr_busy", {31'd0, busy}, 0);
        repeat (5) tick();
        check("mr_no_pop", pop_cnt - p0, 0);
        check("mr_pops_total", pop_cnt - (tx_added - 5), 1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
